irq_request_arbiter: RTL and testbench
======================================

Name: irq_request_arbiter

Overview:
- Collects interrupt events from up to NUM_SRC application sources (DMA channels, doorbells) into per-source pending bits.
- Arbitrates among the pending, unmasked sources with a round-robin scheme.
- Issues one request at a time on the int_valid / int_vector / int_done interface toward the PCIe interrupt controller.
- Sits between the DMA engines and the interrupt controller, and is the requesting end of that handshake.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..32.
- VECTOR_BASE, 0, vector value assigned to source 0; VECTOR_BASE+NUM_SRC must be <= 256.
- COALESCE_CYCLES, 256, hold-off length in i_clk cycles after each completion; used only with IRQ_COALESCE_EN; legal range >= 1.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- src_irq  in  NUM_SRC  per-source event; each cycle a bit is high sets that source's pending bit.
- src_mask  in  NUM_SRC  1 = source masked (excluded from arbitration; its pending bit is still latched).
- pending  out  NUM_SRC  registered pending bits.
- int_valid  out  1  request to the interrupt controller.
- int_vector  out  8  vector of the current request.
- int_done  in  1  single-cycle completion pulse from the interrupt controller.
- busy  out  1  high while the FSM is in any state other than IDLE.

Behaviour:
- Reset values: pending=0, int_valid=0, int_vector=0, busy=0, last_grant=NUM_SRC-1, state=IDLE; hold-off counter=0 when IRQ_COALESCE_EN is defined.
- Reset asserted mid-request: int_valid drops at the next edge, and every pending bit is discarded.
- Pending update, evaluated every cycle:
  - pending_next = (pending & ~clr) | src_irq.
  - clr is the one-hot bit of the source being completed this cycle.
  - If set and clear hit the same bit in the same cycle, set wins: the bit stays 1 and is served again later.
- Eligible vector: elig = pending & ~src_mask.
- State IDLE:
  - If elig != 0: select the first eligible index, searching upward from last_grant+1 and wrapping modulo NUM_SRC.
  - At that edge: register the index as sel, set int_valid<=1 and int_vector<=VECTOR_BASE+sel (8-bit, no overflow by parameter rule), and go to REQ.
  - Latency: src_irq high in cycle N gives pending high in N+1 and int_valid high in N+2 (FSM idle, source unmasked).
- State REQ:
  - int_valid and int_vector stay stable, and src_mask changes do not abort the request.
  - When int_done=1 is sampled: at that edge int_valid<=0, pending[sel] is cleared (subject to set-wins), last_grant<=sel, and the FSM goes to IDLE (or HOLDOFF with the macro).
  - int_valid is therefore low in the cycle after int_done. This guarantees the controller never re-fires on a stale request.
- Minimum gap between requests: int_valid is low for at least 1 cycle, since IDLE is always spent for one full cycle before the next grant.
- int_done sampled in any state other than REQ is ignored.
- busy = (state != IDLE).
- Only pending bits ever change because of src_irq; there is no other side effect.

Optional Feature:
- Macro: IRQ_COALESCE_EN.
- Defined:
  - A completion goes REQ -> HOLDOFF, with the counter loaded to COALESCE_CYCLES-1.
  - The counter decrements each cycle; at 0 the FSM goes to IDLE.
  - The gap from int_valid falling to the next int_valid rising is therefore COALESCE_CYCLES+1 cycles.
  - src_irq events keep accumulating into pending during HOLDOFF, and repeat events on the same source merge into one request.
- Undefined: there is no HOLDOFF state and no counter; REQ goes directly to IDLE. The COALESCE_CYCLES parameter is ignored.

Test Plan:
1. Single event, no macro: src_irq=0x04 for 1 cycle, VECTOR_BASE=0x10, controller answers int_done 3 cycles after int_valid -> int_valid rises 2 cycles after the pulse, int_vector=0x12, int_valid falls the cycle after int_done, pending returns to 0x00, busy falls.
2. Round-robin: src_irq=0x83 in one cycle from reset -> vectors issued in order 0x10, 0x11, 0x17, each separated by at least 1 low cycle of int_valid. A further src_irq=0x01 after the first grant is served after 0x17.
3. Set-wins: src_irq[2] pulsed in the same cycle int_done completes source 2 -> pending[2] stays 1, and a second request with vector 0x12 follows.
4. Masking: src_mask=0x01, src_irq=0x01 -> pending=0x01 and no int_valid for 50 cycles. Clearing src_mask -> a request with vector 0x10 is issued 1 cycle later.
5. Reset mid-REQ: pending=0x0F, i_rst held 1 cycle while int_valid=1 -> next cycle int_valid=0, pending=0, busy=0. A spurious int_done afterwards has no effect.
6. With IRQ_COALESCE_EN, COALESCE_CYCLES=16: three src_irq[0] pulses during HOLDOFF -> exactly one further request with vector 0x10, whose int_valid rises 17 cycles after the previous int_valid fell.

Source files
------------

// File: rtl/irq_request_arbiter.sv
// Round-robin interrupt request arbiter: latches per-source events and issues one vector at a time.
// Optional hold-off after each completion is enabled with `define IRQ_COALESCE_EN.
module irq_request_arbiter #(
   parameter int unsigned NUM_SRC         = 8,
   parameter int unsigned VECTOR_BASE     = 0,
   parameter int unsigned COALESCE_CYCLES = 256
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic [NUM_SRC-1:0] src_mask,
   output logic [NUM_SRC-1:0] pending,
   output logic               int_valid,
   output logic [7:0]         int_vector,
   input  logic               int_done,
   output logic               busy
);

   localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

`ifdef IRQ_COALESCE_EN
   localparam int unsigned CntW = (COALESCE_CYCLES > 1) ? $clog2(COALESCE_CYCLES) : 1;
   typedef enum logic [1:0] {StIdle, StReq, StHoldoff} state_e;
   logic [CntW-1:0] r_cnt;
`else
   typedef enum logic [1:0] {StIdle, StReq} state_e;
`endif

   // Reject illegal configurations at elaboration time.
   if (NUM_SRC < 1 || NUM_SRC > 32 || VECTOR_BASE + NUM_SRC > 256 || COALESCE_CYCLES < 1)
   begin : g_param_check
      $error("irq_request_arbiter: illegal parameter combination");
   end

   state_e            r_state;
   logic [NUM_SRC-1:0] r_pending;
   logic              r_valid;
   logic [7:0]        r_vector;
   logic [IdxW-1:0]   r_sel;
   logic [IdxW-1:0]   r_last_grant;

   logic [NUM_SRC-1:0] w_elig;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic              w_found;
   logic [IdxW-1:0]   w_grant;

   assign w_elig = r_pending & ~src_mask;

   // First eligible index above last_grant, wrapping modulo NUM_SRC.
   always_comb begin
      int unsigned     idx;
      logic [IdxW-1:0] cand;
      w_found = 1'b0;
      w_grant = '0;
      idx     = 0;
      cand    = '0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         idx = k + 32'(r_last_grant);
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         cand = IdxW'(idx);
         if (!w_found && w_elig[cand]) begin
            w_found = 1'b1;
            w_grant = cand;
         end
      end
   end

   // Set wins over clear when both hit the same bit.
   always_comb begin
      w_clr = '0;
      if (r_state == StReq && int_done) w_clr[r_sel] = 1'b1;
      w_pending_nxt = (r_pending & ~w_clr) | src_irq;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_pending    <= '0;
         r_valid      <= 1'b0;
         r_vector     <= 8'h00;
         r_sel        <= '0;
         r_last_grant <= IdxW'(NUM_SRC - 1);
`ifdef IRQ_COALESCE_EN
         r_cnt        <= '0;
`endif
      end else begin
         r_pending <= w_pending_nxt;
         unique case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_sel    <= w_grant;
                  r_valid  <= 1'b1;
                  r_vector <= 8'(VECTOR_BASE) + 8'(w_grant);
                  r_state  <= StReq;
               end
            end
            StReq: begin
               if (int_done) begin
                  r_valid      <= 1'b0;
                  r_last_grant <= r_sel;
`ifdef IRQ_COALESCE_EN
                  r_cnt        <= CntW'(COALESCE_CYCLES - 1);
                  r_state      <= StHoldoff;
`else
                  r_state      <= StIdle;
`endif
               end
            end
`ifdef IRQ_COALESCE_EN
            StHoldoff: begin
               if (r_cnt == '0) r_state <= StIdle;
               else             r_cnt   <= r_cnt - 1'b1;
            end
`endif
            default: r_state <= StIdle;
         endcase
      end
   end

   assign pending    = r_pending;
   assign int_valid  = r_valid;
   assign int_vector = r_vector;
   assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_irq_request_arbiter.sv
// Directed bench for irq_request_arbiter with a vector scoreboard checked on each int_valid rise.
// Coalescing checks run only when the build defines IRQ_COALESCE_EN.
module tb_irq_request_arbiter;

   localparam int unsigned NSrc  = 8;
   localparam int unsigned VBase = 16;
   localparam int unsigned Coal  = 16;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic [NSrc-1:0] src_irq;
   logic [NSrc-1:0] src_mask;
   logic [NSrc-1:0] pending;
   logic            int_valid;
   logic [7:0]      int_vector;
   logic            int_done;
   logic            busy;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   logic [7:0]  exp_q[$];
   logic        prev_valid = 1'b0;

   irq_request_arbiter #(
      .NUM_SRC         (NSrc),
      .VECTOR_BASE     (VBase),
      .COALESCE_CYCLES (Coal)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .src_irq    (src_irq),
      .src_mask   (src_mask),
      .pending    (pending),
      .int_valid  (int_valid),
      .int_vector (int_vector),
      .int_done   (int_done),
      .busy       (busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every new request must match the oldest expected vector.
   always @(negedge i_clk) begin
      if (int_valid === 1'b1 && prev_valid !== 1'b1) begin
         if (exp_q.size() == 0) chk("sb_entry_available", 32'd0, 32'd1);
         else                   chk("sb_vector", 32'(int_vector), 32'(exp_q.pop_front()));
      end
      prev_valid <= int_valid;
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      i_rst    = 1'b1;
      src_irq  = '0;
      src_mask = '0;
      int_done = 1'b0;
      tick();
      i_rst = 1'b0;
      chk({tag, "_rst_pending"}, 32'(pending), 32'h0);
      chk({tag, "_rst_valid"}, 32'(int_valid), 32'h0);
      chk({tag, "_rst_vector"}, 32'(int_vector), 32'h0);
      chk({tag, "_rst_busy"}, 32'(busy), 32'h0);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (int_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_valid_seen"}, 32'(int_valid), 32'h1);
   endtask

   task automatic complete(input string tag);
      int_done = 1'b1;
      tick();
      int_done = 1'b0;
      chk({tag, "_valid_fall"}, 32'(int_valid), 32'h0);
   endtask

   initial begin
      int hits;
      int n;

      // 1: single event, two-cycle latency, clean completion
      do_reset("t1");
      src_irq = 8'h04;
      exp_q.push_back(8'h12);
      tick();
      src_irq = '0;
      chk("t1_pending", 32'(pending), 32'h04);
      chk("t1_valid_n1", 32'(int_valid), 32'h0);
      tick();
      chk("t1_valid_n2", 32'(int_valid), 32'h1);
      chk("t1_vector", 32'(int_vector), 32'h12);
      chk("t1_busy", 32'(busy), 32'h1);
      tick();
      tick();
      complete("t1");
      chk("t1_pending_clr", 32'(pending), 32'h0);
      chk("t1_busy_fall", 32'(busy), 32'h0);

      // 2: round-robin order from reset, plus a late event on source 0
      do_reset("t2");
      src_irq = 8'h83;
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h17);
      exp_q.push_back(8'h10);
      tick();
      src_irq = '0;
      wait_valid("t2a");
      chk("t2a_vector", 32'(int_vector), 32'h10);
      tick();
      complete("t2a");
      src_irq = 8'h01;
      tick();
      src_irq = '0;
      chk("t2b_valid", 32'(int_valid), 32'h1);
      chk("t2b_vector", 32'(int_vector), 32'h11);
      complete("t2b");
      wait_valid("t2c");
      chk("t2c_vector", 32'(int_vector), 32'h17);
      complete("t2c");
      wait_valid("t2d");
      chk("t2d_vector", 32'(int_vector), 32'h10);
      complete("t2d");
      chk("t2_pending_clr", 32'(pending), 32'h0);

      // 3: set wins over the completion clear
      do_reset("t3");
      src_irq = 8'h04;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h12);
      tick();
      src_irq = '0;
      wait_valid("t3a");
      int_done = 1'b1;
      src_irq  = 8'h04;
      tick();
      int_done = 1'b0;
      src_irq  = '0;
      chk("t3_valid_fall", 32'(int_valid), 32'h0);
      chk("t3_pending_kept", 32'(pending), 32'h04);
      wait_valid("t3b");
      chk("t3b_vector", 32'(int_vector), 32'h12);
      complete("t3b");
      chk("t3_pending_clr", 32'(pending), 32'h0);

      // 4: masked source latches but never requests until unmasked
      do_reset("t4");
      src_mask = 8'h01;
      src_irq  = 8'h01;
      tick();
      src_irq = '0;
      chk("t4_pending", 32'(pending), 32'h01);
      hits = 0;
      repeat (50) begin
         tick();
         if (int_valid !== 1'b0) hits++;
      end
      chk("t4_masked_requests", 32'(hits), 32'h0);
      exp_q.push_back(8'h10);
      src_mask = '0;
      tick();
      chk("t4_valid_unmask", 32'(int_valid), 32'h1);
      chk("t4_vector", 32'(int_vector), 32'h10);
      complete("t4");
      chk("t4_pending_clr", 32'(pending), 32'h0);

      // 5: reset in the middle of a request, then a stray int_done
      do_reset("t5");
      src_irq = 8'h0F;
      exp_q.push_back(8'h10);
      tick();
      src_irq = '0;
      wait_valid("t5");
      chk("t5_pending", 32'(pending), 32'h0F);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("t5_valid_rst", 32'(int_valid), 32'h0);
      chk("t5_pending_rst", 32'(pending), 32'h0);
      chk("t5_busy_rst", 32'(busy), 32'h0);
      int_done = 1'b1;
      tick();
      int_done = 1'b0;
      repeat (5) tick();
      chk("t5_valid_after", 32'(int_valid), 32'h0);
      chk("t5_pending_after", 32'(pending), 32'h0);
      chk("t5_busy_after", 32'(busy), 32'h0);

`ifdef IRQ_COALESCE_EN
      // 6: hold-off merges repeated events into one delayed request
      do_reset("t6");
      src_irq = 8'h01;
      exp_q.push_back(8'h10);
      tick();
      src_irq = '0;
      wait_valid("t6a");
      complete("t6a");
      chk("t6_busy_holdoff", 32'(busy), 32'h1);
      exp_q.push_back(8'h10);
      n = 0;
      while (int_valid !== 1'b1 && n < 100) begin
         src_irq = (n == 2 || n == 6 || n == 10) ? 8'h01 : 8'h00;
         tick();
         n++;
      end
      src_irq = '0;
      chk("t6_gap_cycles", 32'(n), 32'(Coal + 1));
      chk("t6_vector", 32'(int_vector), 32'h10);
      complete("t6b");
      hits = 0;
      repeat (40) begin
         tick();
         if (int_valid !== 1'b0) hits++;
      end
      chk("t6_extra_requests", 32'(hits), 32'h0);
`endif

      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
